// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: ROB tag/data widths and the CDB broadcast bundle.
package ooo_pkg;

  localparam int unsigned ROB_ADDR_WIDTH = 4;
  localparam int unsigned DATA_WIDTH     = 32;

  typedef struct packed {
    logic                      valid;
    logic [ROB_ADDR_WIDTH-1:0] tag;
    logic [DATA_WIDTH-1:0]     data;
  } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side valid/ready results and the registered CDB broadcast of cdb_arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned SRC_ID_WIDTH = $clog2(NUM_SRC)
) ();

  logic [NUM_SRC-1:0]                              src_valid;
  logic [NUM_SRC-1:0]                              src_ready;
  logic [NUM_SRC-1:0][ooo_pkg::ROB_ADDR_WIDTH-1:0] src_tag;
  logic [NUM_SRC-1:0][ooo_pkg::DATA_WIDTH-1:0]     src_data;
  logic                                            cdb_valid;
  logic [ooo_pkg::ROB_ADDR_WIDTH-1:0]              cdb_tag;
  logic [ooo_pkg::DATA_WIDTH-1:0]                  cdb_data;
  logic [SRC_ID_WIDTH-1:0]                         cdb_src_id;

  modport master (
    output src_valid, src_tag, src_data,
    input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src_id
  );

  modport slave (
    input  src_valid, src_tag, src_data,
    output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      // ptr is always < N, so one conditional subtract implements the wrap.
      idx = 32'(ptr) + off;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: per-unit 1-entry result slots, round-robin pick, registered CDB.
module cdb_arbiter import ooo_pkg::*; #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned SRC_ID_WIDTH = $clog2(NUM_SRC)
) (
  input logic           clock,
  input logic           reset,
  input logic           flush,
  cdb_arbiter_if.slave  bus
);

  logic [NUM_SRC-1:0]                     slot_v_q, slot_v_d;
  logic [NUM_SRC-1:0][ROB_ADDR_WIDTH-1:0] slot_tag_q, slot_tag_d;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]     slot_data_q, slot_data_d;
  logic [SRC_ID_WIDTH-1:0]                rr_ptr_q, rr_ptr_d;
  cdb_bus_t                               cdb_q, cdb_d;
  logic [SRC_ID_WIDTH-1:0]                cdb_src_id_q, cdb_src_id_d;

  logic [NUM_SRC-1:0]      grant;
  logic [SRC_ID_WIDTH-1:0] grant_idx;
  logic                    any_grant;
  logic [NUM_SRC-1:0]      src_ready;
  logic [NUM_SRC-1:0]      accept;

  rr_arbiter #(
    .N     (NUM_SRC),
    .IDX_W (SRC_ID_WIDTH)
  ) u_rr_arbiter (
    .req       (slot_v_q),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A granted slot empties this edge, so it may be refilled without a bubble.
  assign src_ready = {NUM_SRC{!reset && !flush}} & (~slot_v_q | grant);
  assign accept    = bus.src_valid & src_ready;

  always_comb begin
    slot_v_d     = slot_v_q;
    slot_tag_d   = slot_tag_q;
    slot_data_d  = slot_data_q;
    rr_ptr_d     = rr_ptr_q;
    cdb_d        = cdb_q;
    cdb_src_id_d = cdb_src_id_q;
    cdb_d.valid  = 1'b0;

    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (accept[i]) begin
        slot_v_d[i]    = 1'b1;
        slot_tag_d[i]  = bus.src_tag[i];
        slot_data_d[i] = bus.src_data[i];
      end else if (grant[i]) begin
        slot_v_d[i] = 1'b0;
      end
    end

    if (any_grant) begin
      rr_ptr_d     = (grant_idx == SRC_ID_WIDTH'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
      cdb_d.valid  = 1'b1;
      cdb_d.tag    = slot_tag_q[grant_idx];
      cdb_d.data   = slot_data_q[grant_idx];
      cdb_src_id_d = grant_idx;
    end

    // Squash drops every held result and the pending broadcast; the pointer keeps its place.
    if (flush) begin
      slot_v_d     = '0;
      rr_ptr_d     = rr_ptr_q;
      cdb_d        = cdb_q;
      cdb_d.valid  = 1'b0;
      cdb_src_id_d = cdb_src_id_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_v_q     <= '0;
      slot_tag_q   <= '0;
      slot_data_q  <= '0;
      rr_ptr_q     <= '0;
      cdb_q        <= '0;
      cdb_src_id_q <= '0;
    end else begin
      slot_v_q     <= slot_v_d;
      slot_tag_q   <= slot_tag_d;
      slot_data_q  <= slot_data_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_q        <= cdb_d;
      cdb_src_id_q <= cdb_src_id_d;
    end
  end

  assign bus.src_ready  = src_ready;
  assign bus.cdb_valid  = cdb_q.valid;
  assign bus.cdb_tag    = cdb_q.tag;
  assign bus.cdb_data   = cdb_q.data;
  assign bus.cdb_src_id = cdb_src_id_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a 4-source instance plus a 3-source instance for wrap-around.
module tb_cdb_arbiter;

  logic clock;
  logic reset;
  logic flush;

  int n_checks;
  int n_errors;

  cdb_arbiter_if #(.NUM_SRC(4), .SRC_ID_WIDTH(2)) bus4 ();
  cdb_arbiter_if #(.NUM_SRC(3), .SRC_ID_WIDTH(2)) bus3 ();

  cdb_arbiter #(
    .NUM_SRC      (4),
    .SRC_ID_WIDTH (2)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus4)
  );

  cdb_arbiter #(
    .NUM_SRC      (3),
    .SRC_ID_WIDTH (2)
  ) u_dut3 (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_cdb4(input string tag, input logic v, input logic [3:0] t,
                            input logic [31:0] d, input logic [1:0] id);
    check_eq({tag, ".valid"}, 64'(bus4.cdb_valid), 64'(v));
    check_eq({tag, ".tag"}, 64'(bus4.cdb_tag), 64'(t));
    check_eq({tag, ".data"}, 64'(bus4.cdb_data), 64'(d));
    check_eq({tag, ".src_id"}, 64'(bus4.cdb_src_id), 64'(id));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    flush          = 1'b0;
    bus4.src_valid = '0;
    bus4.src_tag   = '0;
    bus4.src_data  = '0;
    bus3.src_valid = '0;
    bus3.src_tag   = '0;
    bus3.src_data  = '0;
    tick();
    tick();

    // Reset state
    check_cdb4("rst", 1'b0, 4'd0, 32'd0, 2'd0);
    check_eq("rst.ready", 64'(bus4.src_ready), 64'h0);
    reset = 1'b0;
    #1;
    check_eq("rst.ready_rel", 64'(bus4.src_ready), 64'hF);

    // 1: single source on unit 2
    bus4.src_valid   = 4'b0100;
    bus4.src_tag[2]  = 4'd5;
    bus4.src_data[2] = 32'hDEAD_BEEF;
    tick();
    bus4.src_valid = '0;
    check_eq("t1.pre", 64'(bus4.cdb_valid), 64'd0);
    tick();
    check_cdb4("t1.bc", 1'b1, 4'd5, 32'hDEAD_BEEF, 2'd2);
    check_eq("t1.rr", 64'(u_dut.rr_ptr_q), 64'd3);
    tick();
    check_eq("t1.post", 64'(bus4.cdb_valid), 64'd0);

    // 2: all four units streaming from rr_ptr=0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus4.src_tag[i]  = 4'(i + 1);
      bus4.src_data[i] = 32'h100 + 32'(i);
    end
    bus4.src_valid = 4'hF;
    #1;
    check_eq("t2.ready0", 64'(bus4.src_ready), 64'hF);
    tick();
    check_eq("t2.ready1", 64'(bus4.src_ready), 64'b0001);
    check_eq("t2.cdb0", 64'(bus4.cdb_valid), 64'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_cdb4($sformatf("t2.bc%0d", k), 1'b1, 4'(k % 4 + 1), 32'h100 + 32'(k % 4),
                 2'(k % 4));
      check_eq($sformatf("t2.ready%0d", k), 64'(bus4.src_ready), 64'(1 << ((k + 1) % 4)));
    end
    bus4.src_valid = '0;

    // 3: backpressure on unit 0 while its slot waits behind unit 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus4.src_valid   = 4'b0001;
    bus4.src_tag[0]  = 4'd10;
    bus4.src_data[0] = 32'hA0;
    tick();
    bus4.src_valid = '0;
    tick();
    check_cdb4("t3.warm", 1'b1, 4'd10, 32'hA0, 2'd0);
    bus4.src_valid   = 4'b0011;
    bus4.src_tag[0]  = 4'd8;
    bus4.src_data[0] = 32'h80;
    bus4.src_tag[1]  = 4'd9;
    bus4.src_data[1] = 32'h90;
    tick();
    bus4.src_valid   = 4'b0001;
    bus4.src_tag[0]  = 4'd7;
    bus4.src_data[0] = 32'h70;
    #1;
    check_eq("t3.ready_bp", 64'(bus4.src_ready), 64'b1110);
    tick();
    check_cdb4("t3.bc9", 1'b1, 4'd9, 32'h90, 2'd1);
    check_eq("t3.ready_gr", 64'(bus4.src_ready), 64'hF);
    tick();
    bus4.src_valid = '0;
    check_cdb4("t3.bc8", 1'b1, 4'd8, 32'h80, 2'd0);
    tick();
    check_cdb4("t3.bc7", 1'b1, 4'd7, 32'h70, 2'd0);
    tick();
    check_eq("t3.once_a", 64'(bus4.cdb_valid), 64'd0);
    tick();
    check_eq("t3.once_b", 64'(bus4.cdb_valid), 64'd0);
    check_eq("t3.rr", 64'(u_dut.rr_ptr_q), 64'd1);

    // 4: flush with three held results and a concurrent offer on unit 3
    bus4.src_valid = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      bus4.src_tag[i]  = 4'(i + 1);
      bus4.src_data[i] = 32'h400 + 32'(i);
    end
    tick();
    bus4.src_valid   = 4'b1000;
    bus4.src_tag[3]  = 4'd4;
    bus4.src_data[3] = 32'h403;
    flush            = 1'b1;
    #1;
    check_eq("t4.ready", 64'(bus4.src_ready), 64'h0);
    tick();
    flush          = 1'b0;
    bus4.src_valid = '0;
    check_eq("t4.valid", 64'(bus4.cdb_valid), 64'd0);
    check_eq("t4.tag_hold", 64'(bus4.cdb_tag), 64'd7);
    check_eq("t4.rr", 64'(u_dut.rr_ptr_q), 64'd1);
    #1;
    check_eq("t4.ready_empty", 64'(bus4.src_ready), 64'hF);
    tick();
    check_eq("t4.drained_a", 64'(bus4.cdb_valid), 64'd0);
    tick();
    check_eq("t4.drained_b", 64'(bus4.cdb_valid), 64'd0);

    // 6: reset in the middle of a stream
    bus4.src_valid = 4'hF;
    tick();
    tick();
    check_eq("t6.live", 64'(bus4.cdb_valid), 64'd1);
    reset          = 1'b1;
    bus4.src_valid = '0;
    #1;
    check_eq("t6.ready_rst", 64'(bus4.src_ready), 64'h0);
    tick();
    check_cdb4("t6.zero", 1'b0, 4'd0, 32'd0, 2'd0);
    tick();
    check_eq("t6.ready_held", 64'(bus4.src_ready), 64'h0);
    reset = 1'b0;
    tick();
    check_eq("t6.dropped", 64'(bus4.cdb_valid), 64'd0);

    // 5: wrap-around on the 3-source instance, getting rr_ptr to 2 first
    bus3.src_valid   = 3'b001;
    bus3.src_tag[0]  = 4'd1;
    bus3.src_data[0] = 32'h31;
    tick();
    bus3.src_valid = '0;
    tick();
    bus3.src_valid   = 3'b010;
    bus3.src_tag[1]  = 4'd2;
    bus3.src_data[1] = 32'h32;
    tick();
    bus3.src_valid = '0;
    tick();
    check_eq("t5.rr2", 64'(u_dut3.rr_ptr_q), 64'd2);
    bus3.src_valid   = 3'b101;
    bus3.src_tag[0]  = 4'd3;
    bus3.src_data[0] = 32'h33;
    bus3.src_tag[2]  = 4'd5;
    bus3.src_data[2] = 32'h35;
    tick();
    bus3.src_valid = '0;
    tick();
    check_eq("t5.g2.id", 64'(bus3.cdb_src_id), 64'd2);
    check_eq("t5.g2.tag", 64'(bus3.cdb_tag), 64'd5);
    check_eq("t5.rr0", 64'(u_dut3.rr_ptr_q), 64'd0);
    tick();
    check_eq("t5.g0.id", 64'(bus3.cdb_src_id), 64'd0);
    check_eq("t5.g0.tag", 64'(bus3.cdb_tag), 64'd3);
    check_eq("t5.rr1", 64'(u_dut3.rr_ptr_q), 64'd1);
    tick();
    check_eq("t5.idle", 64'(bus3.cdb_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
